sm_reg_monitor: RTL and testbench

//  Board-side register monitor for the schoolMIPS debug port. Selects the core register

---
 rtl/sm_reg_monitor.sv | 172 +++++++++++++++++
 tb/tb_sm_reg_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm_reg_monitor.sv
// Board-side register monitor for the schoolMIPS debug port: key/auto address selection,
// regData capture with leading-zero blanking, and a value-change pulse.

module sm_reg_monitor_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic          r_lvl_q;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // r_press is registered off the accepted level so the event lands DEBOUNCE+3 cycles after the raw edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_lvl   <= 1'b1;
      r_lvl_q <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= key_n;
      r_s2    <= r_s1;
      r_lvl_q <= r_lvl;
      r_press <= r_lvl_q & ~r_lvl;
      if (r_s2 == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(CYCLES - 1)) begin
        r_lvl <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;
endmodule

module sm_reg_monitor #(
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 32,
  parameter int DIGITS          = 6,
  parameter int ADDR_MIN        = 0,
  parameter int ADDR_MAX        = 31,
  parameter int ADDR_RESET      = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DWELL_CYCLES    = 50000000,
  parameter int BLANK_LZ        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  keyNext_n,
  input  logic                  keyPrev_n,
  input  logic                  autoMode,
  input  logic                  freeze,
  input  logic [DATA_W-1:0]     regData,
  output logic [ADDR_W-1:0]     regAddr,
  output logic [ADDR_W-1:0]     addrShown,
  output logic [4*DIGITS-1:0]   dispData,
  output logic [DIGITS-1:0]     digitBlank,
  output logic                  valChanged
);
  localparam int DW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] A_MIN = ADDR_W'(ADDR_MIN);
  localparam logic [ADDR_W-1:0] A_MAX = ADDR_W'(ADDR_MAX);
  localparam logic [ADDR_W-1:0] A_RST = ADDR_W'(ADDR_RESET);
  localparam logic [DIGITS-1:0] BLANK_RST = (BLANK_LZ != 0) ? ~DIGITS'(1) : '0;

  logic                w_next_ev;
  logic                w_prev_ev;
  logic                w_key;
  logic                w_dwell_tc;
  logic [ADDR_W-1:0]   w_inc;
  logic [ADDR_W-1:0]   w_dec;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DW-1:0]       w_dwell_nxt;
  logic [4*DIGITS-1:0] w_cap;
  logic [DIGITS-1:0]   w_blank;
  logic                w_zrun;

  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_shown;
  logic [DW-1:0]       r_dwell;
  logic [4*DIGITS-1:0] r_disp;
  logic [DIGITS-1:0]   r_blank;
  logic                r_vc;

  sm_reg_monitor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst_n(rst_n), .key_n(keyNext_n), .press(w_next_ev)
  );
  sm_reg_monitor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(clk), .rst_n(rst_n), .key_n(keyPrev_n), .press(w_prev_ev)
  );

  assign w_key      = w_next_ev | w_prev_ev;
  assign w_dwell_tc = (r_dwell == DW'(DWELL_CYCLES - 1));
  assign w_inc      = (r_addr == A_MAX) ? A_MIN : r_addr + 1'b1;
  assign w_dec      = (r_addr == A_MIN) ? A_MAX : r_addr - 1'b1;

  // A key event overrides the dwell tick and restarts the dwell period
  always_comb begin
    w_addr_nxt  = r_addr;
    w_dwell_nxt = '0;
    if (w_next_ev && !w_prev_ev) begin
      w_addr_nxt = w_inc;
    end else if (w_prev_ev && !w_next_ev) begin
      w_addr_nxt = w_dec;
    end else if (autoMode && !w_key && w_dwell_tc) begin
      w_addr_nxt = w_inc;
    end
    if (autoMode && !w_key && !w_dwell_tc) begin
      w_dwell_nxt = r_dwell + 1'b1;
    end
  end

  assign w_cap = regData[4*DIGITS-1:0];

  generate
    if (DATA_W > 4*DIGITS) begin : g_unused
      logic w_unused_data;
      assign w_unused_data = ^regData[DATA_W-1:4*DIGITS];
    end
  endgenerate

  // Walk from the top digit down; a digit blanks only while every digit above it is zero
  always_comb begin
    w_blank = '0;
    w_zrun  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zrun     = w_zrun & (w_cap[4*i +: 4] == 4'h0);
      w_blank[i] = (BLANK_LZ != 0) & w_zrun;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= A_RST;
      r_shown <= A_RST;
      r_dwell <= '0;
      r_disp  <= '0;
      r_blank <= BLANK_RST;
      r_vc    <= 1'b0;
    end else begin
      r_addr  <= w_addr_nxt;
      r_dwell <= w_dwell_nxt;
      if (!freeze) begin
        r_disp  <= w_cap;
        r_shown <= r_addr;
        r_blank <= w_blank;
        r_vc    <= (r_addr == r_shown) && (w_cap != r_disp);
      end else begin
        r_vc    <= 1'b0;
      end
    end
  end

  assign regAddr    = r_addr;
  assign addrShown  = r_shown;
  assign dispData   = r_disp;
  assign digitBlank = r_blank;
  assign valChanged = r_vc;
endmodule

// File: tb/tb_sm_reg_monitor.sv
// Directed bench for sm_reg_monitor: debounce timing, address wrap, auto-scan dwell,
// freeze/capture and blanking, with capture expectations queued in a scoreboard.

module tb_sm_reg_monitor;
  localparam int D = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, keyNext_n, keyPrev_n, autoMode, freeze;
  logic [31:0] regData;
  logic [4:0]  regAddr, addrShown, regAddr0, addrShown0;
  logic [23:0] dispData, dispData0;
  logic [5:0]  digitBlank, digitBlank0;
  logic        valChanged, valChanged0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [23:0] data;
    logic [5:0]  blank;
    logic        vc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  sm_reg_monitor #(.DEBOUNCE_CYCLES(D), .DWELL_CYCLES(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .keyNext_n(keyNext_n), .keyPrev_n(keyPrev_n),
    .autoMode(autoMode), .freeze(freeze), .regData(regData),
    .regAddr(regAddr), .addrShown(addrShown), .dispData(dispData),
    .digitBlank(digitBlank), .valChanged(valChanged)
  );

  sm_reg_monitor #(.DEBOUNCE_CYCLES(D), .DWELL_CYCLES(4), .BLANK_LZ(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .keyNext_n(keyNext_n), .keyPrev_n(keyPrev_n),
    .autoMode(autoMode), .freeze(freeze), .regData(regData),
    .regAddr(regAddr0), .addrShown(addrShown0), .dispData(dispData0),
    .digitBlank(digitBlank0), .valChanged(valChanged0)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [4:0] a, input logic [23:0] d,
                          input logic [5:0] b, input logic v);
    exp_t e;
    e.addr = a; e.data = d; e.blank = b; e.vc = v;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_shown"}, 32'(addrShown), 32'(e.addr));
      check({t, "_data"},  32'(dispData),  32'(e.data));
      check({t, "_blank"}, 32'(digitBlank), 32'(e.blank));
      check({t, "_vc"},    32'(valChanged), 32'(e.vc));
    end
  endtask

  task automatic press(input logic nxt, input logic prv);
    keyNext_n = ~nxt;
    keyPrev_n = ~prv;
    tick(D + 6);
    keyNext_n = 1'b1;
    keyPrev_n = 1'b1;
    tick(D + 6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; keyNext_n = 1'b1; keyPrev_n = 1'b1;
    autoMode = 1'b0; freeze = 1'b0; regData = 32'h0000_00A5;
    @(negedge clk);

    // reset state
    push_exp("reset", 5'd2, 24'h0, 6'b111110, 1'b0);
    tick(2);
    pop_check();
    check("reset_addr", 32'(regAddr), 32'd2);
    check("reset_blank_lz0", 32'(digitBlank0), 32'd0);

    // first capture: same address, data 0 -> A5 counts as a change
    rst_n = 1'b1;
    push_exp("cap_a5", 5'd2, 24'h0000A5, 6'b111100, 1'b1);
    tick(1);
    pop_check();
    push_exp("cap_a5_hold", 5'd2, 24'h0000A5, 6'b111100, 1'b0);
    tick(1);
    pop_check();

    // short glitch on next key: no step
    keyNext_n = 1'b0;
    tick(3);
    keyNext_n = 1'b1;
    tick(20);
    check("glitch_no_step", 32'(regAddr), 32'd2);

    // long press: step lands on edge D+3 after the first edge that samples the key
    keyNext_n = 1'b0;
    tick(D + 3);
    check("step_before", 32'(regAddr), 32'd2);
    tick(1);
    check("step_at", 32'(regAddr), 32'd3);
    tick(8);
    keyNext_n = 1'b1;
    tick(20);
    check("release_no_step", 32'(regAddr), 32'd3);
    check("shown_follows", 32'(addrShown), 32'd3);

    // walk down to 0, wrap both ways
    press(1'b0, 1'b1);
    check("prev_3_2", 32'(regAddr), 32'd2);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("prev_to_0", 32'(regAddr), 32'd0);
    press(1'b0, 1'b1);
    check("prev_wrap_31", 32'(regAddr), 32'd31);
    press(1'b1, 1'b0);
    check("next_wrap_0", 32'(regAddr), 32'd0);
    press(1'b1, 1'b1);
    check("both_no_step", 32'(regAddr), 32'd0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("back_to_2", 32'(regAddr), 32'd2);

    // auto scan, 4-cycle dwell
    autoMode = 1'b1;
    tick(3);
    check("auto_hold_2", 32'(regAddr), 32'd2);
    tick(1);
    check("auto_step_3", 32'(regAddr), 32'd3);
    tick(3);
    check("auto_hold_3", 32'(regAddr), 32'd3);
    tick(1);
    check("auto_step_4", 32'(regAddr), 32'd4);
    tick(1);

    // prev event mid-dwell: 4->5->6->7 by dwell, prev -> 6, dwell restarts
    keyPrev_n = 1'b0;
    tick(11);
    check("auto_pre_prev", 32'(regAddr), 32'd7);
    tick(1);
    check("auto_prev_6", 32'(regAddr), 32'd6);
    keyPrev_n = 1'b1;
    tick(3);
    check("auto_restart_hold", 32'(regAddr), 32'd6);
    tick(1);
    check("auto_restart_step", 32'(regAddr), 32'd7);

    autoMode = 1'b0;
    tick(10);
    check("manual_holds", 32'(regAddr), 32'd7);

    // freeze holds capture
    regData = 32'h0000_0005;
    push_exp("data_5", 5'd7, 24'h000005, 6'b111110, 1'b1);
    tick(1);
    pop_check();
    freeze  = 1'b1;
    regData = 32'h0000_0007;
    push_exp("frz1", 5'd7, 24'h000005, 6'b111110, 1'b0);
    tick(1);
    pop_check();
    push_exp("frz2", 5'd7, 24'h000005, 6'b111110, 1'b0);
    tick(1);
    pop_check();
    freeze = 1'b0;
    push_exp("unfrz", 5'd7, 24'h000007, 6'b111110, 1'b1);
    tick(1);
    pop_check();
    push_exp("unfrz_hold", 5'd7, 24'h000007, 6'b111110, 1'b0);
    tick(1);
    pop_check();

    // blanking patterns
    regData = 32'h0001_2000;
    push_exp("blank_mid", 5'd7, 24'h012000, 6'b100000, 1'b1);
    tick(1);
    pop_check();
    regData = 32'hFF12_3456;
    push_exp("blank_none", 5'd7, 24'h123456, 6'b000000, 1'b1);
    tick(1);
    pop_check();
    regData = 32'h0000_0000;
    push_exp("blank_zero", 5'd7, 24'h000000, 6'b111110, 1'b1);
    tick(1);
    pop_check();
    check("blank_lz0_zero", 32'(digitBlank0), 32'd0);

    // reset mid-dwell
    autoMode = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_addr", 32'(regAddr), 32'd2);
    rst_n = 1'b1;
    tick(3);
    check("rst_dwell_hold", 32'(regAddr), 32'd2);
    tick(1);
    check("rst_dwell_step", 32'(regAddr), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
